// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, waits LATENCY cycles, then completes a byte/half/word access.
// Optional macro MEM_RESP_BOUNDS_CHECK_EN turns nonzero address bits above the array into an error.
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [31:0]   r_addr;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_sign_ext;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_index;
  logic [1:0]    w_lane;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_store;
  logic          w_align_err;
  logic          w_oob;
  logic          w_err;

  assign w_index = r_addr[AW+1:2];
  assign w_lane  = r_addr[1:0];
  assign w_word  = r_mem[w_index];

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  assign w_oob = |r_addr[31:AW+2];
`else
  // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
  logic w_unused_upper;
  assign w_unused_upper = ^r_addr[31:AW+2];
  assign w_oob = 1'b0;
`endif

  always_comb begin
    w_align_err = 1'b0;
    case (r_size)
      2'b00:   w_align_err = 1'b0;
      2'b01:   w_align_err = r_addr[0];
      2'b10:   w_align_err = (r_addr[1:0] != 2'b00);
      default: w_align_err = 1'b1;
    endcase
  end

  assign w_err = w_align_err | w_oob;

  always_comb begin
    w_byte = w_word[7:0];
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    w_load = w_word;
    case (r_size)
      2'b00:   w_load = r_sign_ext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      2'b01:   w_load = r_sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: w_load = w_word;
    endcase
  end

  // Merge right-aligned store data into the addressed lanes, keeping the rest of the word.
  always_comb begin
    w_store = w_word;
    case (r_size)
      2'b00: begin
        case (w_lane)
          2'd0:    w_store[7:0]   = r_wdata[7:0];
          2'd1:    w_store[15:8]  = r_wdata[7:0];
          2'd2:    w_store[23:16] = r_wdata[7:0];
          default: w_store[31:24] = r_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (w_lane[1]) w_store[31:16] = r_wdata[15:0];
        else           w_store[15:0]  = r_wdata[15:0];
      end
      2'b10:   w_store = r_wdata;
      default: w_store = w_word;
    endcase
  end

  // The array is not reset; an async reset forces S_IDLE so an aborted store never commits.
  always_ff @(posedge i_clk) begin
    if (r_state == S_RESP && r_we && !w_err) begin
      r_mem[w_index] <= w_store;
    end
  end

  // The ack edge returns to S_IDLE so a held request is re-accepted on the very next edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sign_ext <= 1'b0;
      r_wdata    <= '0;
      o_busy     <= 1'b0;
      o_ack      <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_ack <= 1'b0;
          if (i_req) begin
            r_addr     <= i_mem_addr;
            r_we       <= i_we;
            r_size     <= i_size;
            r_sign_ext <= i_sign_ext;
            r_wdata    <= i_wdata;
            r_count    <= '0;
            o_busy     <= 1'b1;
            r_state    <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_count == WAIT_LAST) begin
            r_state <= S_RESP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_RESP: begin
          o_ack <= 1'b1;
          o_err <= w_err;
          if (w_err) begin
            o_rdata <= '0;
          end else if (!r_we) begin
            o_rdata <= w_load;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters, LATENCY=2).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        signExt;
  logic [31:0] memAddr;
  logic [31:0] wdata;
  logic        busy;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_req      (req),
    .i_we       (we),
    .i_size     (size),
    .i_sign_ext (signExt),
    .i_mem_addr (memAddr),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_ack      (ack),
    .o_rdata    (rdata),
    .o_err      (err)
  );

  // Drives one request and reports ack latency, response values and busy behaviour.
  task automatic transact(input logic isWrite, input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic busyHeld, output logic busyAfter);
    @(negedge clk);
    req = 1'b1; we = isWrite; size = sz; signExt = sx; memAddr = addr; wdata = data;
    @(posedge clk); #1;
    req = 1'b0;
    busyHeld = busy;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      busyHeld = busyHeld & busy;
      if (ack) begin
        lat = c;
        break;
      end
    end
    rd = rdata;
    er = err;
    @(posedge clk); #1;
    busyAfter = busy | ack;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; signExt = 1'b0;
    memAddr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, ack, err} !== 3'b000 || rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy/ack/err=%b%b%b rdata=%h expected 000 and 00000000", busy, ack, err, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, bh, ba);
    checks++;
    if (lat !== 2) begin errors++; $display("[TB] FAIL store_latency: got %0d expected 2", lat); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("[TB] FAIL store_err: got %b expected 0", er); end
    checks++;
    if (bh !== 1'b1 || ba !== 1'b0) begin
      errors++; $display("[TB] FAIL store_busy: held=%b after=%b expected 1 and 0", bh, ba);
    end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      errors++; $display("[TB] FAIL word_load: rdata=%h err=%b lat=%0d expected deadbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF7F, lat, rd, er, bh, ba);
    checks++;
    if (er !== 1'b0) begin errors++; $display("[TB] FAIL byte_store_err: got %b expected 0", er); end
    transact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hFFFFFFDE) begin errors++; $display("[TB] FAIL byte_load_signed: got %h expected ffffffde", rd); end
    transact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'h000000DE) begin errors++; $display("[TB] FAIL byte_load_unsigned: got %h expected 000000de", rd); end
    transact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'h0000007F) begin errors++; $display("[TB] FAIL byte_load_positive: got %h expected 0000007f", rd); end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hDEAD7FEF) begin errors++; $display("[TB] FAIL word_after_byte: got %h expected dead7fef", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
      errors++; $display("[TB] FAIL half_load_signed: got %h err=%b expected ffffdead 0", rd, er);
    end
    transact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'h0000DEAD) begin errors++; $display("[TB] FAIL half_load_unsigned: got %h expected 0000dead", rd); end
    transact(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, lat, rd, er, bh, ba);
    transact(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF5566, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'h0000DEAD || er !== 1'b0) begin
      errors++; $display("[TB] FAIL store_holds_rdata: got %h err=%b expected 0000dead 0", rd, er);
    end
    transact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'h55663344) begin errors++; $display("[TB] FAIL half_store_merge: got %h expected 55663344", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b1, 2'b10, 1'b0, 32'h12, 32'h0BADF00D, lat, rd, er, bh, ba);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++; $display("[TB] FAIL misaligned_word_store: err=%b rdata=%h lat=%0d expected 1 00000000 2", er, rd, lat);
    end
    transact(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL misaligned_half_load: err=%b rdata=%h expected 1 00000000", er, rd);
    end
    transact(1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D, lat, rd, er, bh, ba);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL reserved_size: err=%b rdata=%h expected 1 00000000", er, rd);
    end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hDEAD7FEF || er !== 1'b0) begin
      errors++; $display("[TB] FAIL no_write_on_error: got %h err=%b expected dead7fef 0", rd, er);
    end
  endtask

  task automatic test_upper_bits();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b0, 2'b10, 1'b0, 32'h00000410, 32'h0, lat, rd, er, bh, ba);
    checks++;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("[TB] FAIL out_of_range: err=%b rdata=%h expected 1 00000000", er, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hDEAD7FEF) begin
      errors++; $display("[TB] FAIL address_wrap: err=%b rdata=%h expected 0 dead7fef", er, rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic expAck;
    int ackCount;
    ackCount = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; signExt = 1'b0; memAddr = 32'h10; wdata = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      expAck = ((k % 3) == 2);
      if (ack) ackCount++;
      checks++;
      if (ack !== expAck || busy !== 1'b1) begin
        errors++; $display("[TB] FAIL back_to_back_cycle%0d: ack=%b busy=%b expected %b 1", k, ack, busy, expAck);
      end
      if (k == 11) req = 1'b0;
    end
    checks++;
    if (ackCount !== 4 || rdata !== 32'hDEAD7FEF) begin
      errors++; $display("[TB] FAIL back_to_back_total: acks=%0d rdata=%h expected 4 dead7fef", ackCount, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0) begin
      errors++; $display("[TB] FAIL back_to_back_idle: busy=%b ack=%b expected 0 0", busy, ack);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er, bh, ba;
    transact(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, lat, rd, er, bh, ba);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; signExt = 1'b0; memAddr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_accept: busy=%b expected 1", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL abort_reset_outputs: busy=%b ack=%b rdata=%h expected 0 0 00000000", busy, ack, rdata);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ack%0d: ack=%b expected 0", k, ack); end
    end
    @(negedge clk);
    reset = 1'b0;
    transact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, bh, ba);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_write: got %h err=%b expected cafef00d 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_upper_bits();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
